key_operand_loader: RTL and testbench

- Front-end stage for the 4-bit adder / BCD display path on the DE2-70.
- Replaces the direct switch-to-adder wiring. The user enters operand A on the slide switches and presses a pushbutton, then enters operand B and presses again.
- Debounces two raw pushbuttons (load, clear) and sequences operand capture with a small FSM.
- Presents registered, stable operands plus a valid flag to the downstream adder.

---
 rtl/key_operand_loader.sv | 123 ++++++++++++
 tb/tb_key_operand_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/key_operand_loader.sv
// Pushbutton front end for the 4-bit adder: debounces load/clear keys and
// sequences capture of operands A and B from the slide switches.

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             level;
  logic             level_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= 2'b11;
      cnt     <= '0;
      level   <= 1'b1;
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], key_n};
      level_d <= level;
      // Pulse lands one cycle after the debounced level falls.
      press   <= level_d & ~level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module key_operand_loader #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             key_load_n,
  input  logic             key_clr_n,
  input  logic [WIDTH-1:0] sw_data,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             operands_valid,
  output logic [1:0]       state,
  output logic             load_evt
);
  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    SHOW   = 2'b10
  } state_t;

  logic [1:0] keys_n;
  logic [1:0] press;
  logic       clr_evt;
  state_t     st;

  assign keys_n = {key_clr_n, key_load_n};

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (CLOCK_50),
      .reset (reset),
      .key_n (keys_n[k]),
      .press (press[k])
    );
  end

  assign load_evt = press[0];
  assign clr_evt  = press[1];
  assign state    = st;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      st             <= WAIT_A;
      op_a           <= '0;
      op_b           <= '0;
      operands_valid <= 1'b0;
    end else if (clr_evt) begin
      // Clear wins; a load in the same cycle is dropped.
      st             <= WAIT_A;
      op_a           <= '0;
      op_b           <= '0;
      operands_valid <= 1'b0;
    end else begin
      case (st)
        WAIT_A: if (load_evt) begin
          op_a <= sw_data;
          st   <= WAIT_B;
        end
        WAIT_B: if (load_evt) begin
          op_b           <= sw_data;
          operands_valid <= 1'b1;
          st             <= SHOW;
        end
        SHOW: if (load_evt) begin
          op_a           <= sw_data;
          op_b           <= '0;
          operands_valid <= 1'b0;
          st             <= WAIT_B;
        end
        default: begin
          st             <= WAIT_A;
          op_a           <= '0;
          op_b           <= '0;
          operands_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_key_operand_loader.sv
// Directed bench for key_operand_loader with a 4-cycle debounce window.

module tb_key_operand_loader;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_load_n = 1'b1;
  logic       key_clr_n = 1'b1;
  logic [3:0] sw_data = 4'h0;
  logic [3:0] op_a, op_b;
  logic       operands_valid;
  logic [1:0] state;
  logic       load_evt;

  int total = 0;
  int bad = 0;
  int nevt, first;

  always #5 clk = ~clk;

  key_operand_loader #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .key_load_n     (key_load_n),
    .key_clr_n      (key_clr_n),
    .sw_data        (sw_data),
    .op_a           (op_a),
    .op_b           (op_b),
    .operands_valid (operands_valid),
    .state          (state),
    .load_evt       (load_evt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Hold load low then high, counting load events and the edge of the first.
  task automatic press_load(input logic [3:0] d, input int hold, output int n, output int f);
    n = 0;
    f = -1;
    sw_data = d;
    key_load_n = 1'b0;
    for (int i = 1; i <= hold + 12; i++) begin
      if (i == hold + 1) key_load_n = 1'b1;
      tick();
      if (load_evt) begin
        n++;
        if (f < 0) f = i;
      end
    end
  endtask

  initial begin
    do_reset();
    chk("rst_state", state, 2'b00);
    chk("rst_op_a", op_a, 4'h0);
    chk("rst_op_b", op_b, 4'h0);
    chk("rst_valid", operands_valid, 1'b0);
    chk("rst_evt", load_evt, 1'b0);

    // Clean press, walked edge by edge to pin down the latency.
    sw_data = 4'h5;
    key_load_n = 1'b0;
    nevt = 0;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (load_evt) begin
        nevt++;
        if (first < 0) first = i;
      end
      if (i == 7) chk("t1_op_a_before", op_a, 4'h0);
      if (i == 8) begin
        chk("t1_op_a", op_a, 4'h5);
        chk("t1_state", state, 2'b01);
        chk("t1_valid", operands_valid, 1'b0);
      end
    end
    chk("t1_evt_count", nevt, 1);
    chk("t1_evt_edge", first, 7);
    key_load_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (load_evt) nevt++;
    end
    chk("t1_release_evt", nevt, 1);

    // Full pair from a fresh start.
    do_reset();
    press_load(4'h9, 12, nevt, first);
    chk("t2a_evt", nevt, 1);
    chk("t2a_op_a", op_a, 4'h9);
    chk("t2a_state", state, 2'b01);
    press_load(4'h7, 12, nevt, first);
    chk("t2b_evt", nevt, 1);
    chk("t2_op_a", op_a, 4'h9);
    chk("t2_op_b", op_b, 4'h7);
    chk("t2_valid", operands_valid, 1'b1);
    chk("t2_state", state, 2'b10);

    // New pair started from SHOW without a clear.
    press_load(4'h3, 12, nevt, first);
    chk("t3_op_a", op_a, 4'h3);
    chk("t3_op_b", op_b, 4'h0);
    chk("t3_valid", operands_valid, 1'b0);
    chk("t3_state", state, 2'b01);

    // Bounce train shorter than the debounce window.
    do_reset();
    sw_data = 4'h6;
    nevt = 0;
    for (int i = 0; i < 20; i++) begin
      key_load_n = ((i / 2) % 2) != 0;
      tick();
      if (load_evt) nevt++;
    end
    key_load_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (load_evt) nevt++;
    end
    chk("t4_bounce_evt", nevt, 0);
    chk("t4_bounce_state", state, 2'b00);

    // Same train, this time settling low.
    nevt = 0;
    for (int i = 0; i < 20; i++) begin
      key_load_n = ((i / 2) % 2) != 0;
      tick();
      if (load_evt) nevt++;
    end
    key_load_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (load_evt) nevt++;
    end
    key_load_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (load_evt) nevt++;
    end
    chk("t5_evt", nevt, 1);
    chk("t5_state", state, 2'b01);
    chk("t5_op_a", op_a, 4'h6);

    // Clear and load land together in WAIT_B.
    sw_data = 4'hA;
    key_load_n = 1'b0;
    key_clr_n = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    key_load_n = 1'b1;
    key_clr_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("t6_state", state, 2'b00);
    chk("t6_op_a", op_a, 4'h0);
    chk("t6_op_b", op_b, 4'h0);
    chk("t6_valid", operands_valid, 1'b0);

    // Reset pulse mid-debounce while in SHOW, key still held.
    press_load(4'h9, 12, nevt, first);
    press_load(4'h7, 12, nevt, first);
    chk("t7_pre_state", state, 2'b10);
    sw_data = 4'hC;
    key_load_n = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7_rst_state", state, 2'b00);
    chk("t7_rst_op_a", op_a, 4'h0);
    chk("t7_rst_op_b", op_b, 4'h0);
    chk("t7_rst_valid", operands_valid, 1'b0);
    chk("t7_rst_evt", load_evt, 1'b0);
    nevt = 0;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (load_evt) begin
        nevt++;
        if (first < 0) first = i;
      end
    end
    chk("t7_evt_count", nevt, 1);
    chk("t7_evt_edge", first, 7);
    chk("t7_op_a", op_a, 4'hC);
    chk("t7_state", state, 2'b01);
    key_load_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
